vx_writeback_arb: RTL and testbench

Writeback arbiter for the GPR stage: collects completed results from the execute units (ALU, LSU, CSR, FPU, …), selects one per cycle with round-robin priority and drives the register-file writeback channel (valid/wid/rd/tmask/data, ready). It sits between the commit outputs of the execute units and the write port of the GPR stage. It is the producer end of the writeback interface the GPR stage consumes.

---
 rtl/vx_writeback_arb.sv | 84 ++++++++
 tb/tb_vx_writeback_arb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vx_writeback_arb.sv
// vx_writeback_arb: round-robin selection of execute-unit results into a single registered GPR writeback port
module vx_writeback_arb #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 32,
  parameter int DATAW       = 32,
  localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS    = $clog2(NUM_REGS),
  localparam int LW         = NUM_THREADS * DATAW
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQS-1:0]             req_valid_i,
  output logic [NUM_REQS-1:0]             req_ready_o,
  input  logic [NUM_REQS-1:0]             req_wb_i,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_wid_i,
  input  logic [NUM_REQS*NR_BITS-1:0]     req_rd_i,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask_i,
  input  logic [NUM_REQS*LW-1:0]          req_data_i,
  output logic                            wb_valid_o,
  output logic [NW_BITS-1:0]              wb_wid_o,
  output logic [NR_BITS-1:0]              wb_rd_o,
  output logic [NUM_THREADS-1:0]          wb_tmask_o,
  output logic [LW-1:0]                   wb_data_o,
  input  logic                            wb_ready_i,
  output logic [31:0]                     wb_count_o
);
  localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  logic [NUM_REQS-1:0] elig, gnt_oh;
  logic [PW-1:0] p_q, p_d, gnt_idx;
  logic gnt_any, can_load, valid_q;
  logic [NW_BITS-1:0] wid_q;
  logic [NR_BITS-1:0] rd_q;
  logic [NUM_THREADS-1:0] tmask_q;
  logic [LW-1:0] data_q;
  logic [31:0] count_q;
  assign elig     = req_valid_i & req_wb_i;
  assign can_load = !valid_q || wb_ready_i;
  // Scan from the farthest offset down so the input closest to the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int o = NUM_REQS - 1; o >= 0; o--) begin
      int k;
      k = (int'(p_q) + o) % NUM_REQS;
      if (elig[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
    gnt_any = gnt_any && can_load && rst_ni;
  end
  assign gnt_oh      = gnt_any ? (NUM_REQS'(1) << gnt_idx) : '0;
  assign req_ready_o = (req_valid_i & ~req_wb_i) | gnt_oh;
  assign p_d = gnt_any ? ((gnt_idx == PW'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1) : p_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q     <= '0;
      valid_q <= 1'b0;
      wid_q   <= '0;
      rd_q    <= '0;
      tmask_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      p_q <= p_d;
      if (can_load) valid_q <= gnt_any;
      if (gnt_any) begin
        wid_q   <= req_wid_i[gnt_idx*NW_BITS +: NW_BITS];
        rd_q    <= req_rd_i[gnt_idx*NR_BITS +: NR_BITS];
        tmask_q <= req_tmask_i[gnt_idx*NUM_THREADS +: NUM_THREADS];
        data_q  <= req_data_i[gnt_idx*LW +: LW];
      end
      if (valid_q && wb_ready_i) count_q <= count_q + 32'd1;
    end
  end
  assign wb_valid_o = valid_q;
  assign wb_wid_o   = wid_q;
  assign wb_rd_o    = rd_q;
  assign wb_tmask_o = tmask_q;
  assign wb_data_o  = data_q;
  assign wb_count_o = count_q;
endmodule

// File: tb/tb_vx_writeback_arb.sv
// tb_vx_writeback_arb: directed and random checks of the writeback arbiter against a queue-free reference model
module tb_vx_writeback_arb;
  localparam int N = 4, T = 4, NW = 2, NR = 5, DW = 32, LW = T * DW;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] valid, wb, ready;
  logic [N*NW-1:0] wid;
  logic [N*NR-1:0] rd;
  logic [N*T-1:0] tmask;
  logic [N*LW-1:0] data;
  logic wb_valid, wb_ready;
  logic [NW-1:0] wb_wid;
  logic [NR-1:0] wb_rd;
  logic [T-1:0] wb_tmask;
  logic [LW-1:0] wb_data;
  logic [31:0] wb_count;
  int checks = 0, errors = 0;
  int mp;
  bit mv;
  int unsigned mcount;
  logic [NW-1:0] mwid;
  logic [NR-1:0] mrd;
  logic [T-1:0] mtmask;
  logic [LW-1:0] mdata;

  vx_writeback_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready), .req_wb_i(wb),
    .req_wid_i(wid), .req_rd_i(rd), .req_tmask_i(tmask), .req_data_i(data),
    .wb_valid_o(wb_valid), .wb_wid_o(wb_wid), .wb_rd_o(wb_rd),
    .wb_tmask_o(wb_tmask), .wb_data_o(wb_data),
    .wb_ready_i(wb_ready), .wb_count_o(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input int wi, input int r,
                         input logic [T-1:0] tm, input logic [LW-1:0] d);
    valid[i] = v;
    wb[i] = w;
    wid[i*NW +: NW] = NW'(wi);
    rd[i*NR +: NR] = NR'(r);
    tmask[i*T +: T] = tm;
    data[i*LW +: LW] = d;
  endtask

  task automatic clear();
    valid = '0;
    wb = '0;
  endtask

  // First eligible input walking forward from the pointer, or -1 when nothing may be granted.
  function automatic int pick();
    int k;
    if (!rst_n || (mv && !wb_ready)) return -1;
    for (int o = 0; o < N; o++) begin
      k = (mp + o) % N;
      if (valid[k] && wb[k]) return k;
    end
    return -1;
  endfunction

  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] er;
    #1;
    if (!rst_n) begin
      mv = 0; mp = 0; mcount = 0;
      mwid = '0; mrd = '0; mtmask = '0; mdata = '0;
    end
    g = pick();
    er = valid & ~wb;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, ".ready"}, 128'(ready), 128'(er));
    chk({tag, ".valid"}, 128'(wb_valid), 128'(mv));
    chk({tag, ".count"}, 128'(wb_count), 128'(mcount));
    if (mv || !rst_n) begin
      chk({tag, ".wid"}, 128'(wb_wid), 128'(mwid));
      chk({tag, ".rd"}, 128'(wb_rd), 128'(mrd));
      chk({tag, ".tmask"}, 128'(wb_tmask), 128'(mtmask));
      chk({tag, ".data"}, 128'(wb_data), 128'(mdata));
    end
    if (rst_n) begin
      if (mv && wb_ready) mcount++;
      if (!mv || wb_ready) begin
        mv = (g >= 0);
        if (g >= 0) begin
          mwid = wid[g*NW +: NW];
          mrd = rd[g*NR +: NR];
          mtmask = tmask[g*T +: T];
          mdata = data[g*LW +: LW];
          mp = (g + 1) % N;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    mv = 0; mp = 0; mcount = 0;
    mwid = '0; mrd = '0; mtmask = '0; mdata = '0;
    clear(); wid = '0; rd = '0; tmask = '0; data = '0;
    wb_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1, 1, i, 8 + i, T'(4'hF - i), {4{32'h100 * (i + 1)}});
    repeat (2) cycle("rst");
    chk("rst.count0", 128'(wb_count), 128'(0));
    chk("rst.noready", 128'(ready), 128'(0));
    rst_n = 1'b1;
    repeat (9) cycle("rr");
    chk("rr.count8", 128'(wb_count), 128'(8));
    clear();
    set_req(2, 1, 1, 1, 5, 4'b1011, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    cycle("bp.load");
    clear();
    for (int i = 0; i < N; i++) if (i != 2) set_req(i, 1, 1, i, 20 + i, 4'b0110, {4{$urandom}});
    wb_ready = 1'b0;
    repeat (2) cycle("bp.stall");
    set_req(1, 1, 0, 3, 7, 4'b0001, '0);
    #1;
    chk("nw.ready", 128'(ready), 128'(4'b0010));
    cycle("nw");
    chk("bp.wid", 128'(wb_wid), 128'(1));
    chk("bp.rd", 128'(wb_rd), 128'(5));
    chk("bp.tmask", 128'(wb_tmask), 128'(4'b1011));
    chk("bp.data", 128'(wb_data), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("bp.count9", 128'(wb_count), 128'(9));
    wb_ready = 1'b1;
    cycle("bp.go");
    chk("bp.count10", 128'(wb_count), 128'(10));
    clear();
    set_req(3, 1, 1, 2, 9, 4'b1111, {4{32'h3333}});
    cycle("sp3");
    clear();
    set_req(1, 1, 1, 0, 0, 4'b0000, {4{32'h1111}});
    cycle("sp1");
    chk("sp.valid", 128'(wb_valid), 128'(1));
    chk("sp.rd0", 128'(wb_rd), 128'(0));
    chk("sp.tm0", 128'(wb_tmask), 128'(0));
    for (int i = 0; i < N; i++) set_req(i, 1, 1, i, i, 4'b1111, {4{32'h55 + i}});
    #1;
    chk("sp.p2", 128'(ready), 128'(4'b0100));
    cycle("sp.p2");
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    mcount = 32'hFFFF_FFFF;
    cycle("wrap");
    chk("wrap.count0", 128'(wb_count), 128'(0));
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
                T'($urandom), {$urandom, $urandom, $urandom, $urandom});
      wb_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      cycle("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
